strobe_dec_seq: RTL and testbench

STROBE_DEC_SEQ -- requirements
Module: strobe_dec_seq

---
 rtl/strobe_dec_pkg.sv | 6 +
 rtl/strobe_dec_seq_if.sv | 20 ++
 rtl/strobe_dec_seq_onehot_dec.sv | 11 +
 rtl/strobe_dec_seq.sv | 90 +++++++++
 tb/tb_strobe_dec_seq.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/strobe_dec_pkg.sv
// strobe_dec_pkg: shared state encoding and counter width for the strobe decoder.
package strobe_dec_pkg;
    localparam int PULSE_CNT_W = 8;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_PULSE = 2'd1, ST_WAIT_LOW = 2'd2;
    typedef enum logic [1:0] {IDLE = ST_IDLE, PULSE = ST_PULSE, WAIT_LOW = ST_WAIT_LOW} state_e;
endpackage

// File: rtl/strobe_dec_seq_if.sv
// strobe_dec_seq_if: bus-side strobe/address inputs and decoded strobe outputs.
interface strobe_dec_seq_if #(
    parameter int N_REG = 16,
    parameter int N_DIR = 4
);
    localparam int AW = $clog2(N_REG) + 1;
    logic [AW-1:0]    data_in;
    logic             strob_in;
    logic             clr_ovr;
    logic [N_REG-1:0] strob_out_to_reg;
    logic [N_DIR-1:0] strob_out_to_dir;
    logic             busy;
    logic             done;
    logic             addr_err;
    logic             overrun;
    modport master (output data_in, strob_in, clr_ovr,
                    input strob_out_to_reg, strob_out_to_dir, busy, done, addr_err, overrun);
    modport slave (input data_in, strob_in, clr_ovr,
                   output strob_out_to_reg, strob_out_to_dir, busy, done, addr_err, overrun);
endinterface

// File: rtl/strobe_dec_seq_onehot_dec.sv
// onehot_dec: index to one-hot decoder; out-of-range indices decode to zero.
module onehot_dec #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         i_en,
    input  logic [W-1:0] i_idx,
    output logic [N-1:0] o_onehot
);
    assign o_onehot = i_en ? N'(1) << i_idx : '0;
endmodule

// File: rtl/strobe_dec_seq.sv
// strobe_dec_seq: synchronises an async bus strobe and emits one registered one-hot
// strobe of PULSE_LEN clocks to the addressed register or direction channel.
module strobe_dec_seq
    import strobe_dec_pkg::*;
#(
    parameter int N_REG       = 16,
    parameter int N_DIR       = 4,
    parameter int PULSE_LEN   = 1,
    parameter int SYNC_STAGES = 2
) (
    input logic             clk,
    input logic             rst_n,
    strobe_dec_seq_if.slave bus
);
    localparam int AW = $clog2(N_REG) + 1;
    localparam int IW = AW - 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    state_e                 r_state, w_state;
    logic [PULSE_CNT_W-1:0] r_cnt, w_cnt;
    logic [AW-1:0]          r_addr, w_addr;
    logic [N_REG-1:0]       r_reg, w_reg;
    logic [N_DIR-1:0]       r_dir, w_dir;
    logic                   r_done, r_err, r_ovr;
    logic                   w_synced, w_edge, w_valid, w_pulse;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_edge   = w_synced & ~r_prev;
    assign w_valid  = bus.data_in[AW-1] ? int'(bus.data_in[IW-1:0]) < N_REG
                                        : int'(bus.data_in[IW-1:0]) < N_DIR;

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_addr  = r_addr;
        if (r_state == IDLE && w_edge) begin
            w_state = w_valid ? PULSE : WAIT_LOW;
            w_cnt   = PULSE_CNT_W'(PULSE_LEN - 1);
            w_addr  = bus.data_in;
        end else if (r_state == PULSE) begin
            w_state = (r_cnt != '0) ? PULSE : (w_synced ? WAIT_LOW : IDLE);
            w_cnt   = (r_cnt != '0) ? r_cnt - PULSE_CNT_W'(1) : r_cnt;
        end else if (r_state == WAIT_LOW && !w_synced) begin
            w_state = IDLE;
        end
    end

    // Strobes are decoded from next-state so the output flops align with PULSE.
    assign w_pulse = w_state == PULSE;

    onehot_dec #(.N(N_REG), .W(IW)) u_reg (
        .i_en(w_pulse & w_addr[AW-1]), .i_idx(w_addr[IW-1:0]), .o_onehot(w_reg));
    onehot_dec #(.N(N_DIR), .W(IW)) u_dir (
        .i_en(w_pulse & ~w_addr[AW-1]), .i_idx(w_addr[IW-1:0]), .o_onehot(w_dir));

    // Sync chain and edge register reset high so a strobe held across reset is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '1;
            r_prev  <= 1'b1;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_reg   <= '0;
            r_dir   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.strob_in};
            r_prev  <= w_synced;
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_addr  <= w_addr;
            r_reg   <= w_reg;
            r_dir   <= w_dir;
            r_done  <= w_pulse && w_cnt == '0;
            r_err   <= r_state == IDLE && w_edge && !w_valid;
            r_ovr   <= (r_state != IDLE && w_edge) || (r_ovr && !bus.clr_ovr);
        end
    end

    assign bus.strob_out_to_reg = r_reg;
    assign bus.strob_out_to_dir = r_dir;
    assign bus.busy             = r_state != IDLE;
    assign bus.done             = r_done;
    assign bus.addr_err         = r_err;
    assign bus.overrun          = r_ovr;
endmodule

// File: tb/tb_strobe_dec_seq.sv
// tb_strobe_dec_seq: directed checks of strobe decode, latency, pulse width, overrun and reset.
module tb_strobe_dec_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    strobe_dec_seq_if #(.N_REG(16), .N_DIR(4)) b0 ();
    strobe_dec_seq_if #(.N_REG(16), .N_DIR(4)) b4 ();
    strobe_dec_seq_if #(.N_REG(16), .N_DIR(4)) b8 ();
    strobe_dec_seq_if #(.N_REG(32), .N_DIR(3)) b32 ();

    strobe_dec_seq u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    strobe_dec_seq #(.PULSE_LEN(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    strobe_dec_seq #(.PULSE_LEN(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    strobe_dec_seq #(.N_REG(32), .N_DIR(3)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        b0.data_in = '0;  b0.strob_in = 1'b0;  b0.clr_ovr = 1'b0;
        b4.data_in = '0;  b4.strob_in = 1'b0;  b4.clr_ovr = 1'b0;
        b8.data_in = '0;  b8.strob_in = 1'b0;  b8.clr_ovr = 1'b0;
        b32.data_in = '0; b32.strob_in = 1'b0; b32.clr_ovr = 1'b0;
        tick(3);
        chk("rst_reg", b0.strob_out_to_reg, 16'h0);
        chk("rst_dir", b0.strob_out_to_dir, 4'h0);
        chk("rst_busy", b0.busy, 1'b0);
        chk("rst_flags", {b0.done, b0.addr_err, b0.overrun}, 3'b000);
        rst_n = 1'b1;
        tick(4);

        // Register strobe, PULSE_LEN=1: strobe and done on the third edge
        b0.data_in = 5'h13; b0.strob_in = 1'b1;
        tick(2);
        chk("r13_early", b0.strob_out_to_reg, 16'h0);
        tick(1);
        chk("r13_reg", b0.strob_out_to_reg, 16'h0008);
        chk("r13_done", b0.done, 1'b1);
        chk("r13_busy", b0.busy, 1'b1);
        tick(1);
        chk("r13_reg_off", b0.strob_out_to_reg, 16'h0);
        chk("r13_done_off", b0.done, 1'b0);
        chk("r13_wait_busy", b0.busy, 1'b1);
        tick(2);
        b0.strob_in = 1'b0;
        tick(2);
        chk("r13_busy_hold", b0.busy, 1'b1);
        tick(1);
        chk("r13_idle", b0.busy, 1'b0);

        // Direction strobe, then invalid direction index
        b0.data_in = 5'h02; b0.strob_in = 1'b1;
        tick(3);
        chk("d02_dir", b0.strob_out_to_dir, 4'b0100);
        chk("d02_reg", b0.strob_out_to_reg, 16'h0);
        chk("d02_done", b0.done, 1'b1);
        b0.strob_in = 1'b0;
        tick(1);
        chk("d02_dir_off", b0.strob_out_to_dir, 4'h0);
        tick(4);
        chk("d02_idle", b0.busy, 1'b0);
        b0.data_in = 5'h05; b0.strob_in = 1'b1;
        tick(3);
        chk("d05_err", b0.addr_err, 1'b1);
        chk("d05_strobes", {b0.strob_out_to_reg, b0.strob_out_to_dir}, 20'h0);
        chk("d05_busy", b0.busy, 1'b1);
        chk("d05_done", b0.done, 1'b0);
        tick(1);
        chk("d05_err_off", b0.addr_err, 1'b0);
        b0.strob_in = 1'b0;
        tick(5);
        chk("d05_idle", b0.busy, 1'b0);

        // PULSE_LEN=4 on top register channel
        b4.data_in = 5'h1F; b4.strob_in = 1'b1;
        tick(3);
        chk("p4_c1", {b4.strob_out_to_reg, b4.done}, {16'h8000, 1'b0});
        tick(1);
        chk("p4_c2", {b4.strob_out_to_reg, b4.done}, {16'h8000, 1'b0});
        tick(1);
        chk("p4_c3", {b4.strob_out_to_reg, b4.done}, {16'h8000, 1'b0});
        tick(1);
        chk("p4_c4", {b4.strob_out_to_reg, b4.done}, {16'h8000, 1'b1});
        tick(1);
        chk("p4_end", {b4.strob_out_to_reg, b4.done}, {16'h0, 1'b0});
        b4.strob_in = 1'b0;
        tick(5);
        chk("p4_idle", b4.busy, 1'b0);

        // PULSE_LEN=8 with strobe glitches inside the pulse
        b8.data_in = 5'h11; b8.strob_in = 1'b1;
        tick(3);
        chk("p8_start", b8.strob_out_to_reg, 16'h0002);
        chk("p8_ovr0", b8.overrun, 1'b0);
        b8.strob_in = 1'b0;
        tick(1);
        b8.strob_in = 1'b1;
        tick(3);
        chk("p8_ovr_set", b8.overrun, 1'b1);
        chk("p8_single", b8.strob_out_to_reg, 16'h0002);
        b8.strob_in = 1'b0; b8.clr_ovr = 1'b1;
        tick(1);
        chk("p8_ovr_clr", b8.overrun, 1'b0);
        b8.strob_in = 1'b1; b8.clr_ovr = 1'b0;
        tick(1);
        chk("p8_mid", b8.strob_out_to_reg, 16'h0002);
        tick(1);
        chk("p8_last", {b8.strob_out_to_reg, b8.done, b8.overrun}, {16'h0002, 1'b1, 1'b0});
        b8.clr_ovr = 1'b1;
        tick(1);
        chk("p8_set_wins", b8.overrun, 1'b1);
        chk("p8_end", {b8.strob_out_to_reg, b8.strob_out_to_dir}, 20'h0);
        chk("p8_wait", b8.busy, 1'b1);
        b8.clr_ovr = 1'b0; b8.strob_in = 1'b0;
        tick(5);
        chk("p8_idle", b8.busy, 1'b0);
        b8.clr_ovr = 1'b1;
        tick(1);
        b8.clr_ovr = 1'b0;
        chk("p8_cleared", b8.overrun, 1'b0);

        // Reset mid-pulse drops the strobe asynchronously
        b4.data_in = 5'h1F; b4.strob_in = 1'b1;
        tick(3);
        chk("rmid_on", b4.strob_out_to_reg, 16'h8000);
        b4.strob_in = 1'b0;
        b0.data_in = 5'h13; b0.strob_in = 1'b1;
        rst_n = 1'b0;
        #2;
        chk("rmid_drop", {b4.strob_out_to_reg, b4.done, b4.busy}, {16'h0, 1'b0, 1'b0});
        tick(2);
        rst_n = 1'b1;

        // Strobe held high across reset release: no decode until it cycles
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("rhold_quiet", {b0.strob_out_to_reg, b0.busy}, {16'h0, 1'b0});
        end
        b0.strob_in = 1'b0;
        tick(3);
        b0.strob_in = 1'b1;
        tick(3);
        chk("rhold_fire", b0.strob_out_to_reg, 16'h0008);
        b0.strob_in = 1'b0;
        tick(5);
        chk("rhold_idle", b0.busy, 1'b0);

        // N_REG=32, N_DIR=3
        b32.data_in = 6'h03; b32.strob_in = 1'b1;
        tick(3);
        chk("w03_err", b32.addr_err, 1'b1);
        chk("w03_strobes", {b32.strob_out_to_reg, b32.strob_out_to_dir}, 35'h0);
        b32.strob_in = 1'b0;
        tick(5);
        b32.data_in = 6'h3F; b32.strob_in = 1'b1;
        tick(3);
        chk("w3f_reg", b32.strob_out_to_reg, 32'h8000_0000);
        chk("w3f_done", {b32.done, b32.addr_err}, 2'b10);
        tick(1);
        chk("w3f_off", b32.strob_out_to_reg, 32'h0);
        b32.strob_in = 1'b0;
        tick(5);
        b32.data_in = 6'h02; b32.strob_in = 1'b1;
        tick(3);
        chk("w02_dir", {b32.strob_out_to_dir, b32.strob_out_to_reg}, {3'b100, 32'h0});
        b32.strob_in = 1'b0;
        tick(5);
        chk("w_idle", b32.busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
